// File: rtl/fwd_scoreboard_if.sv
// Decode-stage forwarding bus: operand/stage queries in, bypass selects and hazard state out.
// master = pipeline side driving the queries, slave = the forwarding/hazard unit.
interface fwd_scoreboard_if #(
  parameter int NREAD   = 2,
  parameter int NSTAGES = 3
);
  logic [5*NREAD-1:0]       de_rs;
  logic [NREAD-1:0]         de_rs_used;
  logic [4:0]               de_wb_reg;
  logic                     de_long;
  logic [NSTAGES-1:0]       st_valid;
  logic [5*NSTAGES-1:0]     st_wb_reg;
  logic [NSTAGES-1:0]       st_ready;
  logic                     commit_long;
  logic [4:0]               commit_reg;
  logic                     lc_done;
  logic [4:0]               lc_reg;
  logic [NREAD*NSTAGES-1:0] fwd_sel;
  logic [NREAD-1:0]         fwd_lc;
  logic                     fwd_stall;
  logic                     long_full;
  logic                     sb_err;
  logic [31:0]              stall_cycles;

  modport master (
    output de_rs, de_rs_used, de_wb_reg, de_long,
    output st_valid, st_wb_reg, st_ready,
    output commit_long, commit_reg, lc_done, lc_reg,
    input  fwd_sel, fwd_lc, fwd_stall, long_full, sb_err, stall_cycles
  );

  modport slave (
    input  de_rs, de_rs_used, de_wb_reg, de_long,
    input  st_valid, st_wb_reg, st_ready,
    input  commit_long, commit_reg, lc_done, lc_reg,
    output fwd_sel, fwd_lc, fwd_stall, long_full, sb_err, stall_cycles
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding select and decode hazard unit with a 32-entry long-latency scoreboard
// and a stall-cycle counter. Selects and stall are combinational from inputs and state.
module fwd_scoreboard #(
  parameter int NREAD    = 2,
  parameter int NSTAGES  = 3,
  parameter int MAX_LONG = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  fwd_scoreboard_if.slave bus
);
  localparam int CW = $clog2(MAX_LONG + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LONG);

  logic [31:0]              pending_reg;
  logic [31:0]              pending_next;
  logic [CW-1:0]            count_reg;
  logic [CW-1:0]            count_next;
  logic                     sb_err_reg;
  logic [31:0]              stall_cycles_reg;

  logic [NREAD*NSTAGES-1:0] fwd_sel_c;
  logic [NREAD-1:0]         fwd_lc_c;
  logic [NREAD-1:0]         op_stall_c;
  logic                     waw_stall_c;
  logic                     cap_stall_c;
  logic                     fwd_stall_c;
  logic                     long_full_c;
  logic                     set_ok;
  logic                     clr_ok;
  logic                     err_now;

  assign long_full_c = (count_reg == MAX_CNT);

  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_op
      logic [4:0]         rs;
      logic [NSTAGES-1:0] sel;
      logic               lc_hit;
      logic               stall_req;
      logic               found;

      assign rs = bus.de_rs[5*gi +: 5];

      // Youngest matching stage wins; the lc bus and scoreboard are only consulted
      // when no in-flight stage writes the register.
      always_comb begin
        sel       = '0;
        lc_hit    = 1'b0;
        stall_req = 1'b0;
        found     = 1'b0;
        if (bus.de_rs_used[gi] && rs != 5'd0) begin
          for (int s = 0; s < NSTAGES; s++) begin
            if (!found && bus.st_valid[s] && bus.st_wb_reg[5*s +: 5] == rs) begin
              found  = 1'b1;
              sel[s] = 1'b1;
              if (!bus.st_ready[s]) stall_req = 1'b1;
            end
          end
          if (!found) begin
            if (bus.lc_done && bus.lc_reg == rs) lc_hit = 1'b1;
            else if (pending_reg[rs])            stall_req = 1'b1;
          end
        end
      end

      assign fwd_sel_c[gi*NSTAGES +: NSTAGES] = sel;
      assign fwd_lc_c[gi]                     = lc_hit;
      assign op_stall_c[gi]                   = stall_req;
    end
  endgenerate

  // A same-cycle completion resolves WAW but deliberately does not free capacity.
  assign waw_stall_c = (bus.de_wb_reg != 5'd0) && pending_reg[bus.de_wb_reg]
                     && !(bus.lc_done && bus.lc_reg == bus.de_wb_reg);
  assign cap_stall_c = bus.de_long && long_full_c;
  assign fwd_stall_c = (|op_stall_c) || waw_stall_c || cap_stall_c;

  assign set_ok  = bus.commit_long && bus.commit_reg != 5'd0 && !long_full_c;
  assign clr_ok  = bus.lc_done && pending_reg[bus.lc_reg];
  assign err_now = (bus.lc_done && !pending_reg[bus.lc_reg])
                 || (bus.commit_long && long_full_c);

  // Clear before set so a same-register commit keeps the bit pending.
  always_comb begin
    pending_next = pending_reg;
    if (clr_ok) pending_next[bus.lc_reg]     = 1'b0;
    if (set_ok) pending_next[bus.commit_reg] = 1'b1;
  end

  always_comb begin
    count_next = count_reg;
    case ({set_ok, clr_ok})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_reg      <= '0;
      count_reg        <= '0;
      sb_err_reg       <= 1'b0;
      stall_cycles_reg <= '0;
    end else begin
      pending_reg      <= pending_next;
      count_reg        <= count_next;
      sb_err_reg       <= sb_err_reg | err_now;
      stall_cycles_reg <= stall_cycles_reg + 32'(fwd_stall_c);
    end
  end

  assign bus.fwd_sel      = fwd_sel_c;
  assign bus.fwd_lc       = fwd_lc_c;
  assign bus.fwd_stall    = fwd_stall_c;
  assign bus.long_full    = long_full_c;
  assign bus.sb_err       = sb_err_reg;
  assign bus.stall_cycles = stall_cycles_reg;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: inputs change on the falling edge,
// outputs are checked 1ns later, well away from the rising edge.
module tb_fwd_scoreboard;
  localparam int NREAD    = 2;
  localparam int NSTAGES  = 3;
  localparam int MAX_LONG = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fwd_scoreboard_if #(.NREAD(NREAD), .NSTAGES(NSTAGES)) bus ();

  fwd_scoreboard #(.NREAD(NREAD), .NSTAGES(NSTAGES), .MAX_LONG(MAX_LONG)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.de_rs       = '0;
    bus.de_rs_used  = '0;
    bus.de_wb_reg   = '0;
    bus.de_long     = 1'b0;
    bus.st_valid    = '0;
    bus.st_wb_reg   = '0;
    bus.st_ready    = '0;
    bus.commit_long = 1'b0;
    bus.commit_reg  = '0;
    bus.lc_done     = 1'b0;
    bus.lc_reg      = '0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    #1;
    chk("reset_stall_cycles", bus.stall_cycles, 32'd0);
    chk("reset_long_full",    32'(bus.long_full), 32'd0);
    chk("reset_sb_err",       32'(bus.sb_err), 32'd0);
    chk("reset_fwd_stall",    32'(bus.fwd_stall), 32'd0);
    chk("reset_fwd_sel",      32'(bus.fwd_sel), 32'd0);

    // Two ready stages write x5: the youngest is selected.
    next_cycle();
    bus.de_rs      = {5'd0, 5'd5};
    bus.de_rs_used = 2'b01;
    bus.st_valid   = 3'b011;
    bus.st_wb_reg  = {5'd0, 5'd5, 5'd5};
    bus.st_ready   = 3'b011;
    #1;
    chk("youngest_sel",   32'(bus.fwd_sel), 32'h01);
    chk("youngest_stall", 32'(bus.fwd_stall), 32'd0);
    chk("youngest_lc",    32'(bus.fwd_lc), 32'd0);

    // Load in stage 0 not yet returned, operand 1 reads x7.
    next_cycle();
    clear_inputs();
    bus.de_rs      = {5'd7, 5'd0};
    bus.de_rs_used = 2'b10;
    bus.st_valid   = 3'b001;
    bus.st_wb_reg  = {5'd0, 5'd0, 5'd7};
    bus.st_ready   = 3'b000;
    #1;
    chk("load_sel",   32'(bus.fwd_sel), 32'h08);
    chk("load_stall", 32'(bus.fwd_stall), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      #1;
      chk("load_stall_count", bus.stall_cycles, 32'(i));
    end
    clear_inputs();
    #1;
    chk("load_released", 32'(bus.fwd_stall), 32'd0);

    // Long op on x9: invisible in the commit cycle, stalls next, bypassed on completion.
    next_cycle();
    bus.commit_long = 1'b1;
    bus.commit_reg  = 5'd9;
    bus.de_rs       = {5'd0, 5'd9};
    bus.de_rs_used  = 2'b01;
    #1;
    chk("commit_cycle_nostall", 32'(bus.fwd_stall), 32'd0);
    next_cycle();
    bus.commit_long = 1'b0;
    #1;
    chk("pending_stall", 32'(bus.fwd_stall), 32'd1);
    chk("pending_no_lc", 32'(bus.fwd_lc), 32'd0);
    next_cycle();
    bus.lc_done = 1'b1;
    bus.lc_reg  = 5'd9;
    #1;
    chk("lc_bypass",         32'(bus.fwd_lc), 32'd1);
    chk("lc_bypass_nostall", 32'(bus.fwd_stall), 32'd0);
    next_cycle();
    bus.lc_done = 1'b0;
    #1;
    chk("pending_cleared", 32'(bus.fwd_stall), 32'd0);
    chk("stall_count_4",   bus.stall_cycles, 32'd4);
    chk("no_err_yet",      32'(bus.sb_err), 32'd0);

    // Fill all four long slots.
    clear_inputs();
    for (int r = 1; r <= 4; r++) begin
      next_cycle();
      bus.commit_long = 1'b1;
      bus.commit_reg  = 5'(r);
    end
    next_cycle();
    clear_inputs();
    #1;
    chk("long_full_set", 32'(bus.long_full), 32'd1);
    bus.de_long = 1'b1;
    #1;
    chk("capacity_stall", 32'(bus.fwd_stall), 32'd1);
    next_cycle();
    bus.lc_done = 1'b1;
    bus.lc_reg  = 5'd1;
    #1;
    chk("capacity_same_cycle", 32'(bus.fwd_stall), 32'd1);
    next_cycle();
    bus.lc_done = 1'b0;
    #1;
    chk("long_full_freed",   32'(bus.long_full), 32'd0);
    chk("capacity_released", 32'(bus.fwd_stall), 32'd0);

    // WAW on pending x2, resolved by a same-cycle completion.
    bus.de_long   = 1'b0;
    bus.de_wb_reg = 5'd2;
    #1;
    chk("waw_stall", 32'(bus.fwd_stall), 32'd1);
    next_cycle();
    bus.lc_done = 1'b1;
    bus.lc_reg  = 5'd2;
    #1;
    chk("waw_lc_bypass", 32'(bus.fwd_stall), 32'd0);
    next_cycle();
    bus.lc_done = 1'b0;
    #1;
    chk("waw_cleared",   32'(bus.fwd_stall), 32'd0);
    chk("stall_count_7", bus.stall_cycles, 32'd7);

    // Spurious completion of x12: sticky error, count untouched (x3, x4 still pending).
    clear_inputs();
    bus.lc_done = 1'b1;
    bus.lc_reg  = 5'd12;
    next_cycle();
    bus.lc_done = 1'b0;
    #1;
    chk("sb_err_set", 32'(bus.sb_err), 32'd1);
    bus.commit_long = 1'b1;
    bus.commit_reg  = 5'd5;
    next_cycle();
    bus.commit_reg  = 5'd6;
    next_cycle();
    bus.commit_long = 1'b0;
    #1;
    chk("count_unchanged_full", 32'(bus.long_full), 32'd1);
    chk("sb_err_sticky",        32'(bus.sb_err), 32'd1);

    // Register 0 never matches, even against valid stages writing x0.
    bus.de_rs      = {5'd0, 5'd0};
    bus.de_rs_used = 2'b11;
    bus.st_valid   = 3'b111;
    bus.st_wb_reg  = '0;
    bus.st_ready   = 3'b000;
    #1;
    chk("x0_no_sel",   32'(bus.fwd_sel), 32'd0);
    chk("x0_no_stall", 32'(bus.fwd_stall), 32'd0);

    // Pending x3 stalls, then reset discards everything.
    next_cycle();
    clear_inputs();
    bus.de_rs      = {5'd0, 5'd3};
    bus.de_rs_used = 2'b01;
    #1;
    chk("pre_reset_stall", 32'(bus.fwd_stall), 32'd1);
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    #1;
    chk("post_reset_pending",      32'(bus.fwd_stall), 32'd0);
    chk("post_reset_stall_cycles", bus.stall_cycles, 32'd0);
    chk("post_reset_long_full",    32'(bus.long_full), 32'd0);
    chk("post_reset_sb_err",       32'(bus.sb_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and hazard unit for the decode stage. It generalises bypass selection to NREAD source operands and NSTAGES in-flight pipeline stages. It also adds a registered 32-entry scoreboard that tracks destination registers of committed long-latency operations (mul/div) until their out-of-band completion. It drives per-operand one-hot bypass selects and a single decode stall, and keeps a stall-cycle performance counter.

## Interface
Parameters:
- NREAD, 2, number of decode source operands
- NSTAGES, 3, in-flight stages searched for bypass; stage 0 is youngest (execute)
- MAX_LONG, 4, maximum outstanding long-latency ops (≥1)

Ports:
- clk  in  1  clock; single clock domain
- reset_n  in  1  synchronous, active-low reset
- de_rs  in  5*NREAD  source register of operand p at bits [5p+4:5p]
- de_rs_used  in  NREAD  operand p is actually read
- de_wb_reg  in  5  decode destination register (0 = none)
- de_long  in  1  decode instruction is long-latency
- st_valid  in  NSTAGES  stage s holds a valid writing instruction
- st_wb_reg  in  5*NSTAGES  destination of stage s
- st_ready  in  NSTAGES  stage s result is available for bypass (0 for loads before data return)
- commit_long  in  1  long op leaves the last stage this cycle and is allocated
- commit_reg  in  5  its destination
- lc_done  in  1  long unit writes back this cycle
- lc_reg  in  5  its destination
- fwd_sel  out  NREAD*NSTAGES  one-hot select; bit p*NSTAGES+s = operand p takes stage s
- fwd_lc  out  NREAD  operand p takes the lc writeback bus
- fwd_stall  out  1  decode must hold
- long_full  out  1  outstanding count == MAX_LONG
- sb_err  out  1  sticky: lc_done for a non-pending register
- stall_cycles  out  32  count of cycles with fwd_stall=1

## Operation
- Register 0 never matches any comparison. It is never set pending.
- Per operand p, searched only when de_rs_used[p] = 1 and de_rs[p] ≠ 0, in priority order:
  - Lowest s with st_valid[s] and st_wb_reg[s] == de_rs[p]: set fwd_sel bit. If st_ready[s] = 0, raise a stall request.
  - Else, if lc_done and lc_reg == de_rs[p]: fwd_lc[p] = 1, no stall.
  - Else, if pending[de_rs[p]]: stall request.
  - Else: no bypass; the operand is read from the register file.
- At most one fwd_sel bit per operand. fwd_sel and fwd_lc are mutually exclusive.
- WAW: stall if de_wb_reg ≠ 0, pending[de_wb_reg] = 1, and not (lc_done and lc_reg == de_wb_reg).
- Capacity: stall if de_long and long_full. A same-cycle lc_done does not free the slot early.
- fwd_stall = OR of all stall requests.
- Scoreboard update on each clock edge:
  - commit_long with commit_reg ≠ 0 sets pending[commit_reg] and increments the count.
  - lc_done with pending[lc_reg] clears the bit and decrements the count.
  - Both in the same cycle on different registers: both apply; the count is unchanged.
  - Same register in both: the set wins; the count is unchanged.
  - lc_done on a non-pending register: ignored; sb_err sets.
  - commit_long when count == MAX_LONG: ignored; sb_err sets.
- stall_cycles increments each cycle fwd_stall = 1 and wraps at 2^32.

## Timing
- fwd_sel, fwd_lc and fwd_stall are combinational from inputs and registered state, with zero latency. There are no combinational paths from outputs to inputs.
- A pending bit set by commit_long at edge N is visible to decode from cycle N+1.
- A clearing lc_done is bypassed in the same cycle. The bit reads 0 from cycle N+1.
- Reset (reset_n = 0 at an edge) clears pending, the count, sb_err and stall_cycles. Combinational outputs then follow the cleared state.
- Reset mid-operation discards all outstanding long ops. The long unit is reset by the same signal.
- long_full is registered-state derived and is 0 out of reset.

## Test plan
- de_rs[0]=5, used; st_valid=3'b011, both stages with wb_reg 5, st_ready=3'b011 -> fwd_sel[0]=1 only, fwd_stall=0.
- Load in stage 0 writing x7 with st_ready[0]=0; de_rs[1]=7 -> fwd_sel[NSTAGES]=1, fwd_stall=1; stall_cycles increments each cycle held.
- commit_long reg 9; next cycle de_rs[0]=9 -> fwd_stall=1; lc_done reg 9 a cycle later -> fwd_lc[0]=1, stall=0 that cycle; pending[9]=0 after.
- Four commit_long ops (regs 1-4) with MAX_LONG=4 -> long_full=1; de_long=1 -> stall; the same cycle as lc_done is still stalled; the next cycle is not.
- lc_done reg 12 never committed -> sb_err=1 until reset; count is unchanged.
- de_rs=0 with st_wb_reg=0 valid -> no select, no stall; reset_n low mid-run -> pending, count and stall_cycles read 0 the next cycle.
